single_qubit_gate_engine: RTL and testbench

Applies one 2x2 complex unitary to a chosen target qubit across the whole statevector held in statevector_memory. It is the direct consumer and producer of that memory: it reads each amplitude pair through port A and port B, computes the new pair, and writes it back through port A. The gate sequencer upstream issues one start per single-qubit gate.

---
 rtl/single_qubit_gate_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_single_qubit_gate_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/single_qubit_gate_engine.sv
// Applies a 2x2 complex unitary to one target qubit across the whole statevector, streaming pairs through a dual-port memory.
// Optional build macro GATE_ENGINE_SAT_EN selects saturating results with a sticky sat_flag; without it, results wrap.
module single_qubit_gate_engine #(
  parameter int NUM_QUBITS      = 5,
  parameter int AMPLITUDE_WIDTH = 32,
  localparam int NUM_STATES     = 2 ** NUM_QUBITS,
  localparam int ADDR_W         = $clog2(NUM_STATES),
  localparam int TGT_W          = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1,
  localparam int W              = AMPLITUDE_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TGT_W-1:0]    target,
  input  logic [8*W-1:0]      u_mat,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                sat_flag,
  output logic                mem_a_en,
  output logic                mem_a_we,
  output logic [ADDR_W-1:0]   mem_a_addr,
  output logic [W-1:0]        mem_a_din_re,
  output logic [W-1:0]        mem_a_din_im,
  input  logic [W-1:0]        mem_a_dout_re,
  input  logic [W-1:0]        mem_a_dout_im,
  output logic                mem_b_en,
  output logic [ADDR_W-1:0]   mem_b_addr,
  input  logic [W-1:0]        mem_b_dout_re,
  input  logic [W-1:0]        mem_b_dout_im
);

  localparam int PW    = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam int ACC_W = 2 * W + 2;

  typedef enum logic [2:0] {IDLE, READ, CALC, WR0, WR1, FIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [TGT_W-1:0]  tgt_q, tgt_d;
  logic [8*W-1:0]    u_q, u_d;
  logic [W-1:0]      b1_re_q, b1_re_d, b1_im_q, b1_im_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, sat_q, sat_d;
  logic              a_en_q, a_en_d, a_we_q, a_we_d, b_en_q, b_en_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [W-1:0]      a_din_re_q, a_din_re_d, a_din_im_q, a_din_im_d;

  // Insert a zero at bit position t of pair index pp.
  function automatic logic [ADDR_W-1:0] pair_i0(input logic [PW-1:0] pp, input logic [TGT_W-1:0] t);
    logic [ADDR_W-1:0] pe, lo;
    pe = ADDR_W'(pp);
    lo = (ADDR_W'(1) << t) - ADDR_W'(1);
    return ((pe & ~lo) << 1) | (pe & lo);
  endfunction

  function automatic logic [ADDR_W-1:0] pair_i1(input logic [PW-1:0] pp, input logic [TGT_W-1:0] t);
    return pair_i0(pp, t) | (ADDR_W'(1) << t);
  endfunction

  function automatic logic signed [ACC_W-1:0] mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    logic signed [ACC_W-1:0] xe, ye;
    xe = ACC_W'(x);
    ye = ACC_W'(y);
    return xe * ye;
  endfunction

  // Returns {overflow, value}: floor shift back to Q2 then clamp or wrap.
  function automatic logic [W:0] fix(input logic signed [ACC_W-1:0] acc);
`ifdef GATE_ENGINE_SAT_EN
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> (W - 2);
    if ((&sh[ACC_W-1:W-1]) || !(|sh[ACC_W-1:W-1]))
      return {1'b0, sh[W-1:0]};
    else if (sh[ACC_W-1])
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(W-1){1'b1}}};
`else
    return {1'b0, W'(acc >>> (W - 2))};
`endif
  endfunction

  logic signed [W-1:0] u00r, u00i, u01r, u01i, u10r, u10i, u11r, u11i;
  logic signed [W-1:0] a0r, a0i, a1r, a1i;
  logic signed [ACC_W-1:0] acc_b0r, acc_b0i, acc_b1r, acc_b1i;
  logic [W:0] f_b0r, f_b0i, f_b1r, f_b1i;

  assign u00r = u_q[0*W +: W];
  assign u00i = u_q[1*W +: W];
  assign u01r = u_q[2*W +: W];
  assign u01i = u_q[3*W +: W];
  assign u10r = u_q[4*W +: W];
  assign u10i = u_q[5*W +: W];
  assign u11r = u_q[6*W +: W];
  assign u11i = u_q[7*W +: W];
  assign a0r  = mem_a_dout_re;
  assign a0i  = mem_a_dout_im;
  assign a1r  = mem_b_dout_re;
  assign a1i  = mem_b_dout_im;

  assign acc_b0r = mul(u00r, a0r) - mul(u00i, a0i) + mul(u01r, a1r) - mul(u01i, a1i);
  assign acc_b0i = mul(u00r, a0i) + mul(u00i, a0r) + mul(u01r, a1i) + mul(u01i, a1r);
  assign acc_b1r = mul(u10r, a0r) - mul(u10i, a0i) + mul(u11r, a1r) - mul(u11i, a1i);
  assign acc_b1i = mul(u10r, a0i) + mul(u10i, a0r) + mul(u11r, a1i) + mul(u11i, a1r);
  assign f_b0r = fix(acc_b0r);
  assign f_b0i = fix(acc_b0i);
  assign f_b1r = fix(acc_b1r);
  assign f_b1i = fix(acc_b1i);

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    tgt_d      = tgt_q;
    u_d        = u_q;
    b1_re_d    = b1_re_q;
    b1_im_d    = b1_im_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    sat_d      = sat_q;
    a_en_d     = 1'b0;
    a_we_d     = 1'b0;
    b_en_d     = 1'b0;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_din_re_d = a_din_re_q;
    a_din_im_d = a_din_im_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (32'(target) >= NUM_QUBITS) begin
            state_d = FIN;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d  = READ;
            tgt_d    = target;
            u_d      = u_mat;
            sat_d    = 1'b0;
            err_d    = 1'b0;
            p_d      = '0;
            busy_d   = 1'b1;
            a_en_d   = 1'b1;
            b_en_d   = 1'b1;
            a_addr_d = pair_i0('0, target);
            b_addr_d = pair_i1('0, target);
          end
        end
      end
      READ: state_d = CALC;
      CALC: begin
        state_d    = WR0;
        a_en_d     = 1'b1;
        a_we_d     = 1'b1;
        a_addr_d   = pair_i0(p_q, tgt_q);
        a_din_re_d = f_b0r[W-1:0];
        a_din_im_d = f_b0i[W-1:0];
        b1_re_d    = f_b1r[W-1:0];
        b1_im_d    = f_b1i[W-1:0];
        sat_d      = sat_q | f_b0r[W] | f_b0i[W] | f_b1r[W] | f_b1i[W];
      end
      WR0: begin
        state_d    = WR1;
        a_en_d     = 1'b1;
        a_we_d     = 1'b1;
        a_addr_d   = pair_i1(p_q, tgt_q);
        a_din_re_d = b1_re_q;
        a_din_im_d = b1_im_q;
      end
      WR1: begin
        if (&p_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          state_d  = READ;
          p_d      = p_q + PW'(1);
          a_en_d   = 1'b1;
          b_en_d   = 1'b1;
          a_addr_d = pair_i0(p_q + PW'(1), tgt_q);
          b_addr_d = pair_i1(p_q + PW'(1), tgt_q);
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      p_q        <= '0;
      tgt_q      <= '0;
      u_q        <= '0;
      b1_re_q    <= '0;
      b1_im_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
      a_en_q     <= 1'b0;
      a_we_q     <= 1'b0;
      b_en_q     <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_din_re_q <= '0;
      a_din_im_q <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      tgt_q      <= tgt_d;
      u_q        <= u_d;
      b1_re_q    <= b1_re_d;
      b1_im_q    <= b1_im_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
      a_en_q     <= a_en_d;
      a_we_q     <= a_we_d;
      b_en_q     <= b_en_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_din_re_q <= a_din_re_d;
      a_din_im_q <= a_din_im_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign sat_flag     = sat_q;
  assign mem_a_en     = a_en_q;
  assign mem_a_we     = a_we_q;
  assign mem_a_addr   = a_addr_q;
  assign mem_a_din_re = a_din_re_q;
  assign mem_a_din_im = a_din_im_q;
  assign mem_b_en     = b_en_q;
  assign mem_b_addr   = b_addr_q;

endmodule

// File: tb/tb_single_qubit_gate_engine.sv
// Directed bench for single_qubit_gate_engine: gate vectors against a behavioural dual-port memory plus control corner sequences.
module tb_single_qubit_gate_engine;
  localparam int W  = 32;
  localparam int NS = 32;
  localparam logic [W-1:0] ONE = 32'h4000_0000;
  localparam logic [W-1:0] HV  = 32'h2D41_3CCD;
  localparam logic [W-1:0] HN  = 32'hD2BE_C333;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] target = '0;
  logic [8*W-1:0] u_mat = '0;
  logic busy, done, err, sat_flag;
  logic mem_a_en, mem_a_we, mem_b_en;
  logic [4:0] mem_a_addr, mem_b_addr;
  logic [W-1:0] mem_a_din_re, mem_a_din_im;
  logic [W-1:0] a_dout_re = '0, a_dout_im = '0, b_dout_re = '0, b_dout_im = '0;
  logic [W-1:0] mem_re [NS];
  logic [W-1:0] mem_im [NS];
  int we_cnt = 0, ben_cnt = 0;
  int total = 0, passed = 0;

  single_qubit_gate_engine dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .u_mat(u_mat),
    .busy(busy), .done(done), .err(err), .sat_flag(sat_flag),
    .mem_a_en(mem_a_en), .mem_a_we(mem_a_we), .mem_a_addr(mem_a_addr),
    .mem_a_din_re(mem_a_din_re), .mem_a_din_im(mem_a_din_im),
    .mem_a_dout_re(a_dout_re), .mem_a_dout_im(a_dout_im),
    .mem_b_en(mem_b_en), .mem_b_addr(mem_b_addr),
    .mem_b_dout_re(b_dout_re), .mem_b_dout_im(b_dout_im)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_a_en) begin
      if (mem_a_we) begin
        mem_re[mem_a_addr] <= mem_a_din_re;
        mem_im[mem_a_addr] <= mem_a_din_im;
      end else begin
        a_dout_re <= mem_re[mem_a_addr];
        a_dout_im <= mem_im[mem_a_addr];
      end
    end
    if (mem_b_en) begin
      b_dout_re <= mem_re[mem_b_addr];
      b_dout_im <= mem_im[mem_b_addr];
    end
    if (mem_a_we) we_cnt <= we_cnt + 1;
    if (mem_b_en) ben_cnt <= ben_cnt + 1;
  end

  typedef struct {
    logic [2:0]     tgt;
    logic [8*W-1:0] u;
    int             i0, i1;
    logic [W-1:0]   a0r, a0i, a1r, a1i;
    logic [W-1:0]   e0r, e0i, e1r, e1i;
    logic           esat;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [8*W-1:0] mk_u(input logic [W-1:0] u00r, u00i, u01r, u01i, u10r, u10i, u11r, u11i);
    return {u11i, u11r, u10i, u10r, u01i, u01r, u00i, u00r};
  endfunction

  function automatic vec_t mkv(input logic [2:0] t, input logic [8*W-1:0] u, input int i0, input int i1,
                               input logic [W-1:0] a0r, a0i, a1r, a1i, e0r, e0i, e1r, e1i, input logic es);
    vec_t v;
    v.tgt = t; v.u = u; v.i0 = i0; v.i1 = i1;
    v.a0r = a0r; v.a0i = a0i; v.a1r = a1r; v.a1i = a1i;
    v.e0r = e0r; v.e0i = e0i; v.e1r = e1r; v.e1i = e1i; v.esat = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < NS; k++) begin
      mem_re[k] = '0;
      mem_im[k] = '0;
    end
  endtask

  task automatic issue(input logic [2:0] t, input logic [8*W-1:0] u);
    @(posedge clk); #1;
    start = 1'b1; target = t; u_mat = u;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, nz;
    clear_mem();
    mem_re[v.i0] = v.a0r; mem_im[v.i0] = v.a0i;
    mem_re[v.i1] = v.a1r; mem_im[v.i1] = v.a1i;
    issue(v.tgt, v.u);
    chk($sformatf("v%0d_rd_en", idx), {31'b0, mem_a_en & mem_b_en & ~mem_a_we}, 32'd1);
    chk($sformatf("v%0d_rd_addr_a", idx), {27'b0, mem_a_addr}, 32'd0);
    chk($sformatf("v%0d_rd_addr_b", idx), {27'b0, mem_b_addr}, 32'd1 << v.tgt);
    wait_done(lat);
    chk($sformatf("v%0d_latency", idx), lat, 32'd65);
    chk($sformatf("v%0d_err", idx), {31'b0, err}, 32'd0);
    chk($sformatf("v%0d_sat", idx), {31'b0, sat_flag}, {31'b0, v.esat});
    chk($sformatf("v%0d_b0_re", idx), mem_re[v.i0], v.e0r);
    chk($sformatf("v%0d_b0_im", idx), mem_im[v.i0], v.e0i);
    chk($sformatf("v%0d_b1_re", idx), mem_re[v.i1], v.e1r);
    chk($sformatf("v%0d_b1_im", idx), mem_im[v.i1], v.e1i);
    nz = 0;
    for (int k = 0; k < NS; k++)
      if (k != v.i0 && k != v.i1 && (mem_re[k] != 0 || mem_im[k] != 0)) nz++;
    chk($sformatf("v%0d_others_zero", idx), nz, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_busy_after", idx), {31'b0, busy}, 32'd0);
    chk($sformatf("v%0d_done_pulse", idx), {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [8*W-1:0] ux;
    logic [W-1:0] sat_re;
    logic sat_exp;
    int n, ndone, done_at, we0, ben0;

`ifdef GATE_ENGINE_SAT_EN
    sat_re = 32'h7FFF_FFFF; sat_exp = 1'b1;
`else
    sat_re = 32'h8000_0000; sat_exp = 1'b0;
`endif
    ux = mk_u(0, 0, ONE, 0, ONE, 0, 0, 0);
    vecs[0] = mkv(3'd0, ux, 0, 1, ONE, 0, 0, 0, 0, 0, ONE, 0, 1'b0);
    vecs[1] = mkv(3'd2, mk_u(HV, 0, HV, 0, HV, 0, HN, 0), 0, 4, ONE, 0, 0, 0, HV, 0, HV, 0, 1'b0);
    vecs[2] = mkv(3'd1, mk_u(ONE, 0, 0, 0, 0, 0, 0, ONE), 0, 2, 0, 0, ONE, 0, 0, 0, 0, ONE, 1'b0);
    vecs[3] = mkv(3'd0, mk_u(ONE, 0, ONE, 0, 0, 0, 0, 0), 0, 1, ONE, 0, ONE, 0, sat_re, 0, 0, 0, sat_exp);
    vecs[4] = mkv(3'd3, mk_u(ONE, 0, 0, 0, 0, 0, 32'hC000_0000, 0), 5, 13,
                  32'h1000_0000, 32'hF800_0000, 32'h0123_4567, 0,
                  32'h1000_0000, 32'hF800_0000, 32'hFEDC_BA99, 0, 1'b0);
    vecs[5] = mkv(3'd4, mk_u(32'h2000_0000, 0, 0, 0, 0, 32'h2000_0000, 0, 0), 3, 19,
                  32'd3, 32'hFFFF_FFFD, ONE, 0, 32'd1, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0);

    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_sat", {31'b0, sat_flag}, 0);
    chk("rst_en", {29'b0, mem_a_en, mem_a_we, mem_b_en}, 0);
    chk("rst_addr", {22'b0, mem_a_addr, mem_b_addr}, 0);
    chk("rst_din", mem_a_din_re | mem_a_din_im, 0);
    rst = 1'b0;

    // Out-of-range targets are rejected immediately without touching memory.
    we0 = we_cnt; ben0 = ben_cnt;
    issue(3'd5, ux);
    chk("rej5_done", {31'b0, done}, 1);
    chk("rej5_err", {31'b0, err}, 1);
    @(posedge clk); #1;
    chk("rej5_done_pulse", {31'b0, done}, 0);
    chk("rej5_err_hold", {31'b0, err}, 1);
    issue(3'd7, ux);
    chk("rej7_done", {31'b0, done}, 1);
    chk("rej7_err", {31'b0, err}, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("rej_no_we", we_cnt - we0, 0);
    chk("rej_no_ben", ben_cnt - ben0, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // A second start mid-operation is ignored.
    clear_mem();
    mem_re[0] = ONE;
    issue(3'd0, ux);
    n = 1; ndone = 0; done_at = 0;
    while (n <= 90) begin
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = n;
      end
      if (n == 10) begin
        start = 1'b1; target = 3'd1; u_mat = vecs[1].u;
      end
      if (n == 11) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_done_at", done_at, 65);
    chk("ign_amp0", mem_re[0], 0);
    chk("ign_amp1", mem_re[1], ONE);
    chk("ign_amp2", mem_re[2], 0);

    // Reset in the middle of an operation.
    clear_mem();
    mem_re[0] = ONE;
    issue(3'd0, ux);
    n = 1;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_busy_before", {31'b0, busy}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_en", {29'b0, mem_a_en, mem_a_we, mem_b_en}, 0);
    chk("mid_rst_done", {31'b0, done}, 0);
    rst = 1'b0;
    run_vec(vecs[0], 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
